// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - red/green/yellow sequencer for a bi-colour signal head
//
// Automatic RED -> GREEN -> YELLOW -> RED cycling with parameterised dwell
// times, plus a manual override that forces a colour on the next edge.
// Yellow is shown by lighting both lamps.
//
// Ports:
//   clk              system clock, all state changes on the rising edge
//   reset            synchronous, active-high; forces RED with a full red dwell
//   manual_override  1 = lamps follow manual_state, 0 = automatic sequencing
//   manual_state     forced colour: 00 red, 01 yellow, 10 green, 11 red
//   R                red lamp (registered decode of state)
//   G                green lamp (registered decode of state)

module traffic_light_controller #(
  parameter int RED_CYCLES    = 10,
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       manual_override,
  input  logic [1:0] manual_state,
  output logic       R,
  output logic       G
);

  // A dwell of 0 is treated as 1 so every phase is visible for at least one cycle.
  localparam int RED_EFF    = (RED_CYCLES    < 1) ? 1 : RED_CYCLES;
  localparam int GREEN_EFF  = (GREEN_CYCLES  < 1) ? 1 : GREEN_CYCLES;
  localparam int YELLOW_EFF = (YELLOW_CYCLES < 1) ? 1 : YELLOW_CYCLES;

  localparam int MAX_RG   = (RED_EFF > GREEN_EFF) ? RED_EFF : GREEN_EFF;
  localparam int MAX_DW   = (MAX_RG > YELLOW_EFF) ? MAX_RG : YELLOW_EFF;
  localparam int CW       = (MAX_DW > 1) ? $clog2(MAX_DW) : 1;

  localparam logic [CW-1:0] RED_LOAD    = CW'(RED_EFF - 1);
  localparam logic [CW-1:0] GREEN_LOAD  = CW'(GREEN_EFF - 1);
  localparam logic [CW-1:0] YELLOW_LOAD = CW'(YELLOW_EFF - 1);

  typedef enum logic [1:0] {
    S_RED    = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  // Remembers that the previous edge was under override, so the first
  // automatic edge afterwards can restart the sequence with a full red phase.
  logic          manual_q;
  logic          manual_q_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RED;
      count    <= RED_LOAD;
      manual_q <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      manual_q <= manual_q_next;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = count;
    manual_q_next = manual_override;

    if (manual_override) begin
      // Override wins over any automatic expiry on the same edge.
      case (manual_state)
        2'b01:   state_next = S_YELLOW;
        2'b10:   state_next = S_GREEN;
        default: state_next = S_RED;
      endcase
      count_next = RED_LOAD;
    end else if (manual_q) begin
      // Release edge loads the red dwell, so it counts as the first red cycle.
      state_next = S_RED;
      count_next = RED_LOAD;
    end else if (count != '0) begin
      count_next = count - CW'(1);
    end else begin
      case (state)
        S_RED: begin
          state_next = S_GREEN;
          count_next = GREEN_LOAD;
        end
        S_GREEN: begin
          state_next = S_YELLOW;
          count_next = YELLOW_LOAD;
        end
        default: begin
          state_next = S_RED;
          count_next = RED_LOAD;
        end
      endcase
    end
  end

  // Lamps are a pure decode of the state register: no path from the inputs.
  assign R = (state != S_GREEN);
  assign G = (state != S_RED);

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - scoreboard bench for traffic_light_controller

module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       manual_override = 1'b0;
  logic [1:0] manual_state = 2'b00;
  logic       r_a, g_a, r_b, g_b, r_c, g_c;

  always #5 clk = ~clk;

  traffic_light_controller dut_a (
    .clk(clk), .reset(reset), .manual_override(manual_override),
    .manual_state(manual_state), .R(r_a), .G(g_a)
  );

  traffic_light_controller #(.RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .manual_override(manual_override),
    .manual_state(manual_state), .R(r_b), .G(g_b)
  );

  traffic_light_controller #(.RED_CYCLES(0), .GREEN_CYCLES(1), .YELLOW_CYCLES(0)) dut_c (
    .clk(clk), .reset(reset), .manual_override(manual_override),
    .manual_state(manual_state), .R(r_c), .G(g_c)
  );

  int errors = 0;
  int checks = 0;

  // Expected {R,G} for dut_a, dut_b, dut_c after the next rising edge.
  logic [5:0] exp_q[$];

  // Reference model: edges elapsed since the last automatic (re)start.
  int  t_auto = 0;
  bit  prev_ov = 1'b0;

  function automatic logic [1:0] auto_colour(int t, int r, int g, int y);
    int rr, gg, yy, p;
    rr = (r < 1) ? 1 : r;
    gg = (g < 1) ? 1 : g;
    yy = (y < 1) ? 1 : y;
    p  = t % (rr + gg + yy);
    if (p < rr)           return 2'b10;
    else if (p < rr + gg) return 2'b01;
    else                  return 2'b11;
  endfunction

  function automatic logic [1:0] manual_colour(logic [1:0] ms);
    case (ms)
      2'b01:   return 2'b11;
      2'b10:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic step(input logic rst, input logic ov, input logic [1:0] ms);
    logic [1:0] ea, eb, ec;
    @(negedge clk);
    reset = rst;
    manual_override = ov;
    manual_state = ms;
    if (rst) begin
      t_auto = 0;
      prev_ov = 1'b0;
      ea = 2'b10; eb = 2'b10; ec = 2'b10;
    end else if (ov) begin
      prev_ov = 1'b1;
      ea = manual_colour(ms); eb = ea; ec = ea;
    end else begin
      if (prev_ov) t_auto = 0;
      else         t_auto = t_auto + 1;
      prev_ov = 1'b0;
      ea = auto_colour(t_auto, 10, 8, 3);
      eb = auto_colour(t_auto, 1, 1, 1);
      ec = auto_colour(t_auto, 0, 1, 0);
    end
    exp_q.push_back({ea, eb, ec});
  endtask

  task automatic compare(input string name, input logic [1:0] got, input logic [1:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got R=%0b G=%0b, want R=%0b G=%0b",
               name, $time, got[1], got[0], want[1], want[0]);
    end
  endtask

  // Monitor: after every rising edge, pop the pending expectation and compare.
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("dut_a_default", {r_a, g_a}, e[5:4]);
        compare("dut_b_ones",    {r_b, g_b}, e[3:2]);
        compare("dut_c_zeros",   {r_c, g_c}, e[1:0]);
      end
    end
  end

  initial begin
    // Reset then a full automatic period and a bit more.
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 2'b00);

    // Manual forcing of each code.
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b1, 2'b00);
    step(1'b0, 1'b1, 2'b11);

    // Force green, then release: full red dwell then green.
    step(1'b0, 1'b1, 2'b10);
    step(1'b0, 1'b1, 2'b10);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 2'b00);

    // Reset priority over override, then override takes effect after release.
    step(1'b1, 1'b1, 2'b10);
    step(1'b0, 1'b1, 2'b10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00);

    // Override collision on the edge where green would expire.
    step(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b1, 2'b00);
    step(1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 2'b00);

    // Randomised traffic: occasional resets, override toggling, colour changes.
    begin
      logic ov;
      ov = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(7) == 0) ov = ~ov;
        step(($urandom_range(49) == 0), ov, 2'($urandom_range(3)));
      end
    end

    @(posedge clk);
    #2;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
